// File: rtl/char_buffer_scheduler_if.sv
// Write-port bundle between command_handler (requesters) and the
// character-buffer scheduler, including the registered char_buffer write side.
interface char_buffer_scheduler_if #(
  parameter int unsigned ADDR_BITS = 11
);
  logic                 a_valid;
  logic                 a_ready;
  logic [ADDR_BITS-1:0] a_addr;
  logic [7:0]           a_data;
  logic                 fill_valid;
  logic                 fill_ready;
  logic [ADDR_BITS-1:0] fill_start;
  logic [ADDR_BITS:0]   fill_len;
  logic [7:0]           fill_data;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [7:0]           wr_data;
  logic                 wr_en;
  logic                 busy;
  logic                 fill_done;

  // Requester side: issues single writes and fill commands, observes the buffer port.
  modport master (
    output a_valid, a_addr, a_data, fill_valid, fill_start, fill_len, fill_data,
    input  a_ready, fill_ready, wr_addr, wr_data, wr_en, busy, fill_done
  );

  // Scheduler side.
  modport slave (
    input  a_valid, a_addr, a_data, fill_valid, fill_start, fill_len, fill_data,
    output a_ready, fill_ready, wr_addr, wr_data, wr_en, busy, fill_done
  );
endinterface

// File: rtl/char_buffer_scheduler.sv
// char_buffer_scheduler: arbitrates the single char_buffer write port between
// single-character writes (A) and a block-fill engine (clear screen/line, scroll
// blanking). Writes appear on wr_* one cycle after their grant.
// Optional macro CHARBUF_ROUND_ROBIN_EN: round-robin A/fill arbitration during
// FILL; when undefined, A has strict priority over the fill engine.
module char_buffer_scheduler #(
  parameter int unsigned ROWS      = 25,
  parameter int unsigned COLS      = 80,
  parameter int unsigned ADDR_BITS = 11
) (
  input  logic                    clk,
  input  logic                    rstn,
  char_buffer_scheduler_if.slave  bus
);

  localparam int unsigned DEPTH = ROWS * COLS;
  localparam logic [ADDR_BITS:0]   DEPTH_C   = (ADDR_BITS+1)'(DEPTH);
  localparam logic [ADDR_BITS:0]   CNT_ONE   = (ADDR_BITS+1)'(1);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);
  localparam logic [ADDR_BITS-1:0] ADDR_ONE  = ADDR_BITS'(1);

  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t               state, state_nx;
  logic [ADDR_BITS-1:0] ptr, ptr_nx;
  logic [ADDR_BITS:0]   cnt, cnt_nx;
  logic [7:0]           fch, fch_nx;

  logic                 a_grant;
  logic                 f_grant;
  logic                 done_nx;
  logic                 we_nx;
  logic                 a_ready_c;
  logic                 fill_ready_c;

  logic [ADDR_BITS-1:0] wr_addr_q;
  logic [7:0]           wr_data_q;
  logic                 wr_en_q;
  logic                 fill_done_q;

`ifdef CHARBUF_ROUND_ROBIN_EN
  typedef enum logic {G_A, G_FILL} grant_t;
  grant_t last_grant, last_grant_nx;
`endif

  // Next-state, handshake readies and grant selection.
  always_comb begin
    state_nx     = state;
    ptr_nx       = ptr;
    cnt_nx       = cnt;
    fch_nx       = fch;
    a_grant      = 1'b0;
    f_grant      = 1'b0;
    done_nx      = 1'b0;
    a_ready_c    = 1'b0;
    fill_ready_c = 1'b0;
`ifdef CHARBUF_ROUND_ROBIN_EN
    last_grant_nx = last_grant;
`endif
    case (state)
      S_IDLE: begin
        a_ready_c    = 1'b1;
        fill_ready_c = 1'b1;
        a_grant      = bus.a_valid;
        if (bus.fill_valid) begin
          ptr_nx = ({1'b0, bus.fill_start} >= DEPTH_C) ? '0 : bus.fill_start;
          cnt_nx = (bus.fill_len > DEPTH_C) ? DEPTH_C : bus.fill_len;
          fch_nx = bus.fill_data;
          if (cnt_nx == '0) done_nx  = 1'b1;
          else              state_nx = S_FILL;
        end
      end
      S_FILL: begin
`ifdef CHARBUF_ROUND_ROBIN_EN
        if (bus.a_valid && last_grant == G_FILL) begin
          a_ready_c     = 1'b1;
          a_grant       = 1'b1;
          last_grant_nx = G_A;
        end else begin
          f_grant       = 1'b1;
          last_grant_nx = G_FILL;
        end
`else
        a_ready_c = bus.a_valid;
        a_grant   = bus.a_valid;
        f_grant   = !bus.a_valid;
`endif
        if (f_grant) begin
          ptr_nx = (ptr == LAST_ADDR) ? '0 : ptr + ADDR_ONE;
          cnt_nx = cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state_nx = S_IDLE;
            done_nx  = 1'b1;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // A write to an out-of-range address completes its handshake but is dropped.
  assign we_nx = (a_grant && ({1'b0, bus.a_addr} < DEPTH_C)) || f_grant;

  // FSM and fill-engine registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
      ptr   <= '0;
      cnt   <= '0;
      fch   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      cnt   <= cnt_nx;
      fch   <= fch_nx;
    end
  end

`ifdef CHARBUF_ROUND_ROBIN_EN
  // Remembers who won the last FILL-state arbitration.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) last_grant <= G_FILL;
    else       last_grant <= last_grant_nx;
  end
`endif

  // Registered char_buffer write port and completion pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      fill_done_q <= 1'b0;
    end else begin
      wr_en_q     <= we_nx;
      fill_done_q <= done_nx;
      if (we_nx) begin
        wr_addr_q <= a_grant ? bus.a_addr : ptr;
        wr_data_q <= a_grant ? bus.a_data : fch;
      end
    end
  end

  assign bus.a_ready    = a_ready_c;
  assign bus.fill_ready = fill_ready_c;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.fill_done  = fill_done_q;
  assign bus.busy       = (state == S_FILL);

endmodule

// File: tb/tb_char_buffer_scheduler.sv
// Directed bench for char_buffer_scheduler: single writes, fills, wrap/clamp,
// contention ordering, and reset behaviour.
module tb_char_buffer_scheduler;

  logic clk;
  logic rstn;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  char_buffer_scheduler_if #(.ADDR_BITS(11)) bus ();

  char_buffer_scheduler #(
    .ROWS(25),
    .COLS(80),
    .ADDR_BITS(11)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Write log captured away from the active edge.
  int wq_addr[$];
  int wq_data[$];
  int wq_busy[$];
  int wq_done[$];
  int wq_cyc[$];
  int done_total = 0;

  always @(negedge clk) begin
    if (bus.fill_done) done_total = done_total + 1;
    if (bus.wr_en) begin
      wq_addr.push_back(int'(bus.wr_addr));
      wq_data.push_back(int'(bus.wr_data));
      wq_busy.push_back(int'(bus.busy));
      wq_done.push_back(int'(bus.fill_done));
      wq_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
    wq_busy.delete();
    wq_done.delete();
    wq_cyc.delete();
    done_total = 0;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_fill(input int start, input int len, input int data);
    bus.fill_valid = 1'b1;
    bus.fill_start = 11'(start);
    bus.fill_len   = 12'(len);
    bus.fill_data  = 8'(data);
  endtask

  initial begin
    int bad;
    int bad_busy;
    int na;
    int got;
    int exp_ord[8];
    int exp_done_idx;

    rstn = 1'b0;
    bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
    bus.fill_valid = 1'b0; bus.fill_start = '0; bus.fill_len = '0; bus.fill_data = '0;

    // Reset state
    #12;
    chk("rst_wr_en", int'(bus.wr_en), 0);
    chk("rst_wr_addr", int'(bus.wr_addr), 0);
    chk("rst_wr_data", int'(bus.wr_data), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_fill_done", int'(bus.fill_done), 0);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // IDLE single write
    bus.a_valid = 1'b1; bus.a_addr = 11'd5; bus.a_data = 8'h41;
    #1;
    chk("idle_a_ready", int'(bus.a_ready), 1);
    chk("idle_fill_ready", int'(bus.fill_ready), 1);
    tick();
    bus.a_valid = 1'b0;
    chk("a_wr_en", int'(bus.wr_en), 1);
    chk("a_wr_addr", int'(bus.wr_addr), 5);
    chk("a_wr_data", int'(bus.wr_data), 'h41);
    tick();
    chk("a_wr_en_off", int'(bus.wr_en), 0);

    // Clear line 160..239
    clear_log();
    start_fill(160, 80, 'h20);
    #1;
    chk("line_fill_ready", int'(bus.fill_ready), 1);
    tick();
    bus.fill_valid = 1'b0;
    chk("line_busy_next", int'(bus.busy), 1);
    chk("line_no_wr_yet", int'(bus.wr_en), 0);
    tick();
    chk("line_first_wr", int'(bus.wr_en), 1);
    chk("line_first_addr", int'(bus.wr_addr), 160);
    repeat (85) tick();
    chk("line_count", wq_addr.size(), 80);
    if (wq_addr.size() == 80) begin
      bad = 0; bad_busy = 0;
      for (int i = 0; i < 80; i++) begin
        if (wq_addr[i] != 160 + i || wq_data[i] != 'h20) bad++;
        if (wq_busy[i] != ((i < 79) ? 1 : 0)) bad_busy++;
      end
      chk("line_addr_data", bad, 0);
      chk("line_busy", bad_busy, 0);
      chk("line_back_to_back", wq_cyc[79] - wq_cyc[0], 79);
      chk("line_done_on_last", wq_done[79], 1);
    end
    chk("line_done_total", done_total, 1);
    chk("line_busy_after", int'(bus.busy), 0);

    // Wrap: 1990..1999, 0..9
    clear_log();
    start_fill(1990, 20, 'h2D);
    tick();
    bus.fill_valid = 1'b0;
    repeat (25) tick();
    chk("wrap_count", wq_addr.size(), 20);
    if (wq_addr.size() == 20) begin
      bad = 0;
      for (int i = 0; i < 20; i++) if (wq_addr[i] != (1990 + i) % 2000) bad++;
      chk("wrap_addr", bad, 0);
      chk("wrap_done_on_last", wq_done[19], 1);
    end

    // Clamp: len 3000 -> 2000 writes ending at 1989
    clear_log();
    start_fill(1990, 3000, 'h20);
    tick();
    bus.fill_valid = 1'b0;
    repeat (2010) tick();
    chk("clamp_count", wq_addr.size(), 2000);
    if (wq_addr.size() == 2000) begin
      bad = 0;
      for (int i = 0; i < 2000; i++) if (wq_addr[i] != (1990 + i) % 2000) bad++;
      chk("clamp_addr", bad, 0);
      chk("clamp_last_addr", wq_addr[1999], 1989);
    end
    chk("clamp_done_total", done_total, 1);

    // Contention: fill 0..3 against A stream 100..103
    clear_log();
    start_fill(0, 4, 'h2E);
    tick();
    bus.fill_valid = 1'b0;
`ifdef CHARBUF_ROUND_ROBIN_EN
    tick();
    exp_ord = '{0, 100, 1, 101, 2, 102, 3, 103};
    exp_done_idx = 6;
`else
    exp_ord = '{100, 101, 102, 103, 0, 1, 2, 3};
    exp_done_idx = 7;
`endif
    na = 0;
    for (int k = 0; k < 20 && na < 4; k++) begin
      bus.a_valid = 1'b1;
      bus.a_addr  = 11'(100 + na);
      bus.a_data  = 8'(8'h61 + na);
      #1;
      got = int'(bus.a_ready);
      tick();
      if (got == 1) na++;
    end
    bus.a_valid = 1'b0;
    chk("cont_a_accepted", na, 4);
    repeat (8) tick();
    chk("cont_count", wq_addr.size(), 8);
    if (wq_addr.size() == 8) begin
      bad = 0;
      for (int i = 0; i < 8; i++) begin
        if (wq_addr[i] != exp_ord[i]) bad++;
        if (wq_done[i] != ((i == exp_done_idx) ? 1 : 0)) bad++;
      end
      chk("cont_order", bad, 0);
    end

    // len=0: no writes, done next cycle, busy never set
    clear_log();
    start_fill(7, 0, 'h20);
    tick();
    bus.fill_valid = 1'b0;
    chk("len0_done", int'(bus.fill_done), 1);
    chk("len0_busy", int'(bus.busy), 0);
    tick();
    chk("len0_done_pulse", int'(bus.fill_done), 0);
    repeat (2) tick();
    chk("len0_no_writes", wq_addr.size(), 0);

    // Out-of-range single write is dropped
    clear_log();
    bus.a_valid = 1'b1; bus.a_addr = 11'd2000; bus.a_data = 8'h5A;
    #1;
    chk("oor_a_ready", int'(bus.a_ready), 1);
    tick();
    bus.a_valid = 1'b0;
    chk("oor_wr_en", int'(bus.wr_en), 0);
    tick();
    chk("oor_no_writes", wq_addr.size(), 0);

    // Simultaneous A + fill in IDLE
    clear_log();
    bus.a_valid = 1'b1; bus.a_addr = 11'd50; bus.a_data = 8'h42;
    start_fill(10, 2, 'h20);
    tick();
    bus.a_valid = 1'b0; bus.fill_valid = 1'b0;
    repeat (5) tick();
    chk("both_count", wq_addr.size(), 3);
    if (wq_addr.size() == 3) begin
      chk("both_first_a", wq_addr[0], 50);
      chk("both_fill_order", wq_addr[1] * 10000 + wq_addr[2], 10 * 10000 + 11);
    end

    // Reset mid-fill
    clear_log();
    start_fill(0, 100, 'h20);
    tick();
    bus.fill_valid = 1'b0;
    repeat (5) tick();
    rstn = 1'b0;
    #1;
    chk("mid_rst_wr_en", int'(bus.wr_en), 0);
    chk("mid_rst_busy", int'(bus.busy), 0);
    repeat (2) tick();
    @(negedge clk);
    rstn = 1'b1;
    tick();
    chk("mid_rst_fill_ready", int'(bus.fill_ready), 1);
    repeat (3) tick();
    chk("mid_rst_no_done", done_total, 0);
    chk("mid_rst_idle_wr_en", int'(bus.wr_en), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout reached observed=running expected=finished");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/char_buffer_scheduler.md
Name: char_buffer_scheduler

Overview:
- Arbitrates the single write port of the character buffer between two requesters:
  - single-character writes from the command handler;
  - a block-fill engine that sequences runs of writes for clear-screen, clear-line and scroll blanking.
- Sits between command_handler and char_buffer in the clk domain.
- Read side and video_generator are untouched.

Parameters:
ROWS, 25, text rows
COLS, 80, text columns; buffer depth DEPTH = ROWS*COLS (2000)
ADDR_BITS, 11, buffer address width

Ports:
clk  in  1  system clock (video/command domain)
rstn  in  1  asynchronous active-low reset
a_valid  in  1  single-write request
a_ready  out  1  single-write accepted this cycle
a_addr  in  ADDR_BITS  single-write address
a_data  in  8  single-write character
fill_valid  in  1  fill request
fill_ready  out  1  fill request accepted this cycle
fill_start  in  ADDR_BITS  first address of fill
fill_len  in  ADDR_BITS+1  number of characters to write
fill_data  in  8  fill character (e.g. 8'h20)
wr_addr  out  ADDR_BITS  char_buffer waddr (registered)
wr_data  out  8  char_buffer din (registered)
wr_en  out  1  char_buffer wen (registered)
busy  out  1  high while in FILL
fill_done  out  1  one-cycle pulse when a fill completes

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE; wr_en=0, wr_addr=0, wr_data=0, busy=0, fill_done=0.
  - last_grant=FILL; internal ptr/cnt=0.
  - Reset mid-fill aborts immediately; no fill_done pulse.
- Handshakes are valid/ready. Transfer occurs when valid&&ready at a rising clk. Requester data must stay stable while valid && !ready.
- Write latency: the granted transfer appears on wr_addr/wr_data/wr_en exactly 1 cycle later. At most one write per cycle.
- a_ready and fill_ready are combinational from state, valid inputs and last_grant.
- Single writes:
  - a_addr >= DEPTH: handshake completes, write is dropped (wr_en stays 0).
- FSM IDLE:
  - fill_ready=1, a_ready=1.
  - A single write accepted in IDLE is issued next cycle.
  - On fill accept: latch ptr=fill_start, cnt=min(fill_len, DEPTH), char=fill_data.
  - fill_start >= DEPTH: ptr=0.
  - cnt==0: stay IDLE, pulse fill_done next cycle, no writes.
  - Otherwise go to FILL; busy=1 from next cycle.
  - fill_valid and a_valid in the same IDLE cycle: both accepted. The A write issues next cycle; the fill's first write can be issued no earlier than the cycle after that.
- FSM FILL:
  - fill_ready=0.
  - Each cycle one of A or fill is granted:
    - a_valid=1 and last_grant==FILL: grant A (a_ready=1).
    - Otherwise: grant fill (a_ready=0).
    - last_grant updates to the granted requester.
  - No a_valid: fill writes back-to-back, 1 char/cycle.
  - Fill grant: issue write(ptr, char), then cnt-=1 and ptr+=1, wrapping DEPTH-1 -> 0. The wrap handles the circular buffer with a scroll offset.
  - The grant that takes cnt 1->0 returns to IDLE.
  - fill_done pulses in the cycle that last fill write is on wr_en.
  - busy drops in the same cycle.
- Ordering: writes reach the buffer in grant order. A later fill write may overwrite an earlier A write to the same address, and vice versa. This is required behaviour; no hazard checking.
- fill_len > DEPTH is clamped to DEPTH, so each location is written at most once per fill.

Optional Feature:
- Macro: CHARBUF_ROUND_ROBIN_EN.
- Defined: FILL-state arbitration is round-robin as above. Worst-case fill rate is 1 char per 2 cycles while A is saturated.
- Undefined:
  - A has strict priority in FILL: a_ready=a_valid; fill is granted only when a_valid=0.
  - last_grant is not implemented.
  - A continuous A stream stalls the fill indefinitely. busy stays high and no writes are lost.

Test Plan:
- Reset then IDLE write: a_valid with addr=5, data=8'h41 for 1 cycle -> a_ready=1 that cycle; next cycle wr_en=1, wr_addr=5, wr_data=8'h41; then wr_en=0.
- Clear line: fill start=160, len=80, data=8'h20, no A traffic -> 80 consecutive wr_en cycles at addresses 160..239, first one 2 cycles after accept. busy high throughout; fill_done coincident with addr 239.
- Wrap and clamp:
  - start=1990, len=20 -> addresses 1990..1999 then 0..9.
  - len=3000 -> exactly 2000 writes, ending at address 1989.
- Contention (RR) at fill start=0, len=4, with a_valid held for addr=100..103 during FILL -> alternating grants fill/A. Buffer order: 0,100,1,101,2,102,3, with fill_done on address 3, then A write 103.
- Without macro, same stimulus -> A writes 100..103 first, then fill 0..3. Fill never granted while a_valid=1.
- Edge cases:
  - len=0 -> no writes; fill_done one cycle after accept; busy never set.
  - a_addr=2000 -> a_ready=1, no wr_en.
  - rstn low mid-fill -> wr_en=0 immediately and no fill_done; after release, IDLE with fill_ready=1.
